// File: rtl/pipeline_ctrl_chain.sv
// pipeline_ctrl_chain: parametrised control-path pipeline (ID/EX .. MEM/WB)
// with per-stage valid bits, load-use bubble insertion, branch flush,
// external freeze and saturating stall/flush performance counters.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   id_valid, id_ctrl   ID instruction present / its control word
//   id_rd, id_rd_we     ID destination register and its write enable
//   id_is_load          ID instruction is a load
//   id_rn, id_rm        ID source registers
//   id_use_rn/_rm       source register actually read
//   branch_taken        branch resolved taken in stage 0 this cycle
//   ext_stall           freeze the whole pipeline
//   pc_enable           PC register enable (combinational)
//   if_id_enable        IF/ID register enable (combinational)
//   if_id_flush         IF/ID clear to NOP (combinational)
//   load_use_stall      load-use bubble inserted this cycle (combinational)
//   stage_valid/_ctrl/_rd/_we  registered per-stage state, stage k at slice k
//   stall_cnt, flush_cnt       saturating performance counters
module pipeline_ctrl_chain #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned STAGES = 3,
  parameter int unsigned RA_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [CTRL_W-1:0]        id_ctrl,
  input  logic [RA_W-1:0]          id_rd,
  input  logic                     id_rd_we,
  input  logic                     id_is_load,
  input  logic [RA_W-1:0]          id_rn,
  input  logic [RA_W-1:0]          id_rm,
  input  logic                     id_use_rn,
  input  logic                     id_use_rm,
  input  logic                     branch_taken,
  input  logic                     ext_stall,
  output logic                     pc_enable,
  output logic                     if_id_enable,
  output logic                     if_id_flush,
  output logic                     load_use_stall,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [STAGES*RA_W-1:0]   stage_rd,
  output logic [STAGES-1:0]        stage_we,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Per-stage state
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] we_q, we_d;
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];
  logic [RA_W-1:0]   rd_q   [STAGES];
  logic [RA_W-1:0]   rd_d   [STAGES];
  logic              is_load_q, is_load_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic hz_c;
  logic bubble0_c;
  logic src_match_c;

  // Load-use hazard: stage 0 holds a writing load whose result ID needs now
  always_comb begin
    src_match_c = (id_use_rn && (id_rn == rd_q[0])) ||
                  (id_use_rm && (id_rm == rd_q[0]));
    hz_c        = valid_q[0] && is_load_q && we_q[0] && id_valid && src_match_c;
  end

  // Stage 0 takes a bubble on flush, on a hazard, or when ID is empty
  assign bubble0_c = branch_taken || hz_c || !id_valid;

  // Front-end enables, priority reset > ext_stall > branch > hazard > normal
  always_comb begin
    pc_enable      = 1'b1;
    if_id_enable   = 1'b1;
    if_id_flush    = 1'b0;
    load_use_stall = 1'b0;
    if (!reset) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      if_id_flush  = 1'b1;
    end else if (ext_stall) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
    end else if (hz_c) begin
      pc_enable      = 1'b0;
      if_id_enable   = 1'b0;
      load_use_stall = 1'b1;
    end
  end

  // Next-state for the stage chain; ext_stall freezes everything
  always_comb begin
    valid_d   = valid_q;
    we_d      = we_q;
    is_load_d = is_load_q;
    for (int k = 0; k < int'(STAGES); k++) begin
      ctrl_d[k] = ctrl_q[k];
      rd_d[k]   = rd_q[k];
    end

    if (!ext_stall) begin
      for (int k = 1; k < int'(STAGES); k++) begin
        valid_d[k] = valid_q[k-1];
        we_d[k]    = we_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      if (bubble0_c) begin
        valid_d[0] = 1'b0;
        we_d[0]    = 1'b0;
        ctrl_d[0]  = '0;
        rd_d[0]    = '0;
        is_load_d  = 1'b0;
      end else begin
        valid_d[0] = 1'b1;
        we_d[0]    = id_rd_we;
        ctrl_d[0]  = id_ctrl;
        rd_d[0]    = id_rd;
        is_load_d  = id_is_load;
      end
    end
  end

  // Saturating counters; a taken branch masks any coincident hazard
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ext_stall) begin
      if (branch_taken) begin
        if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (hz_c) begin
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      we_q        <= '0;
      is_load_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        ctrl_q[k] <= '0;
        rd_q[k]   <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      we_q        <= we_d;
      is_load_q   <= is_load_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        ctrl_q[k] <= ctrl_d[k];
        rd_q[k]   <= rd_d[k];
      end
    end
  end

  // Flatten stage arrays onto the output buses
  for (genvar g = 0; g < int'(STAGES); g++) begin : g_flat
    assign stage_ctrl[g*CTRL_W +: CTRL_W] = ctrl_q[g];
    assign stage_rd[g*RA_W +: RA_W]       = rd_q[g];
  end

  assign stage_valid = valid_q;
  assign stage_we    = we_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_chain.sv
// Scoreboard bench for pipeline_ctrl_chain: driver applies stimulus on the
// falling edge and pushes the reference model's expectation; an independent
// monitor pops and compares front-end enables (before the rising edge) and
// the registered stage state / counters (after the rising edge).
module tb_pipeline_ctrl_chain;

  localparam int unsigned CW   = 8;
  localparam int unsigned S    = 3;
  localparam int unsigned RW   = 4;
  localparam int unsigned CNTW = 4;
  localparam int          CMAX = (1 << CNTW) - 1;

  logic            clk;
  logic            reset;
  logic            id_valid;
  logic [CW-1:0]   id_ctrl;
  logic [RW-1:0]   id_rd;
  logic            id_rd_we;
  logic            id_is_load;
  logic [RW-1:0]   id_rn;
  logic [RW-1:0]   id_rm;
  logic            id_use_rn;
  logic            id_use_rm;
  logic            branch_taken;
  logic            ext_stall;
  logic            pc_enable;
  logic            if_id_enable;
  logic            if_id_flush;
  logic            load_use_stall;
  logic [S-1:0]    stage_valid;
  logic [S*CW-1:0] stage_ctrl;
  logic [S*RW-1:0] stage_rd;
  logic [S-1:0]    stage_we;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  pipeline_ctrl_chain #(
    .CTRL_W(CW), .STAGES(S), .RA_W(RW), .CNT_W(CNTW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_ctrl       (id_ctrl),
    .id_rd         (id_rd),
    .id_rd_we      (id_rd_we),
    .id_is_load    (id_is_load),
    .id_rn         (id_rn),
    .id_rm         (id_rm),
    .id_use_rn     (id_use_rn),
    .id_use_rm     (id_use_rm),
    .branch_taken  (branch_taken),
    .ext_stall     (ext_stall),
    .pc_enable     (pc_enable),
    .if_id_enable  (if_id_enable),
    .if_id_flush   (if_id_flush),
    .load_use_stall(load_use_stall),
    .stage_valid   (stage_valid),
    .stage_ctrl    (stage_ctrl),
    .stage_rd      (stage_rd),
    .stage_we      (stage_we),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an array of in-flight instructions
  typedef struct {
    logic          valid;
    logic [CW-1:0] ctrl;
    logic [RW-1:0] rd;
    logic          we;
    logic          ld;
  } inst_t;

  typedef struct {
    logic            pc;
    logic            ifid;
    logic            flush;
    logic            lus;
    logic [S-1:0]    pre_valid;
    logic [S-1:0]    valid;
    logic [S*CW-1:0] ctrl;
    logic [S*RW-1:0] rd;
    logic [S-1:0]    we;
    logic [CNTW-1:0] sc;
    logic [CNTW-1:0] fc;
  } exp_t;

  inst_t m_pipe [S];
  int    m_stall;
  int    m_flush;
  exp_t  sb_q [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [S-1:0] model_valid();
    logic [S-1:0] v;
    for (int k = 0; k < int'(S); k++) v[k] = m_pipe[k].valid;
    return v;
  endfunction

  // One cycle of stimulus plus the model's view of its outcome
  task automatic cycle(input logic rst, input logic idv, input logic [CW-1:0] ctrl,
                       input logic [RW-1:0] rd, input logic we, input logic ld,
                       input logic [RW-1:0] rn, input logic [RW-1:0] rm,
                       input logic urn, input logic urm, input logic br, input logic xs);
    exp_t  e;
    inst_t bubble;
    logic  hz;
    bubble = '{valid: 1'b0, ctrl: '0, rd: '0, we: 1'b0, ld: 1'b0};
    @(negedge clk);
    reset = rst; id_valid = idv; id_ctrl = ctrl; id_rd = rd; id_rd_we = we;
    id_is_load = ld; id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm;
    branch_taken = br; ext_stall = xs;

    if (!rst) begin
      for (int k = 0; k < int'(S); k++) m_pipe[k] = bubble;
      m_stall = 0;
      m_flush = 0;
      e.pc = 1'b0; e.ifid = 1'b0; e.flush = 1'b1; e.lus = 1'b0;
      e.pre_valid = '0;
    end else begin
      e.pre_valid = model_valid();
      hz = idv && m_pipe[0].valid && m_pipe[0].ld && m_pipe[0].we &&
           ((urn && rn == m_pipe[0].rd) || (urm && rm == m_pipe[0].rd));
      e.pc    = !xs && (br || !hz);
      e.ifid  = e.pc;
      e.flush = !xs && br;
      e.lus   = !xs && !br && hz;
      if (!xs) begin
        for (int k = int'(S) - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        if (br || hz || !idv) m_pipe[0] = bubble;
        else m_pipe[0] = '{valid: 1'b1, ctrl: ctrl, rd: rd, we: we, ld: ld};
        if (br) m_flush = (m_flush < CMAX) ? m_flush + 1 : m_flush;
        else if (hz) m_stall = (m_stall < CMAX) ? m_stall + 1 : m_stall;
      end
    end

    for (int k = 0; k < int'(S); k++) begin
      e.valid[k]          = m_pipe[k].valid;
      e.we[k]             = m_pipe[k].valid && m_pipe[k].we;
      e.ctrl[k*CW +: CW]  = m_pipe[k].ctrl;
      e.rd[k*RW +: RW]    = m_pipe[k].rd;
    end
    e.sc = CNTW'(m_stall);
    e.fc = CNTW'(m_flush);
    sb_q.push_back(e);
  endtask

  task automatic nop();
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [CW-1:0] c, input logic [RW-1:0] rd,
                     input logic [RW-1:0] rn, input logic [RW-1:0] rm,
                     input logic urn, input logic urm);
    cycle(1'b1, 1'b1, c, rd, 1'b1, 1'b0, rn, rm, urn, urm, 1'b0, 1'b0);
  endtask

  task automatic ldr(input logic [CW-1:0] c, input logic [RW-1:0] rd);
    cycle(1'b1, 1'b1, c, rd, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: combinational outputs before the edge, state after it
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("pc_enable",      64'(pc_enable),      64'(e.pc));
        chk("if_id_enable",   64'(if_id_enable),   64'(e.ifid));
        chk("if_id_flush",    64'(if_id_flush),    64'(e.flush));
        chk("load_use_stall", 64'(load_use_stall), 64'(e.lus));
        chk("stage_valid_pre",64'(stage_valid),    64'(e.pre_valid));
        @(posedge clk);
        #1;
        chk("stage_valid", 64'(stage_valid), 64'(e.valid));
        chk("stage_ctrl",  64'(stage_ctrl),  64'(e.ctrl));
        chk("stage_rd",    64'(stage_rd),    64'(e.rd));
        chk("stage_we",    64'(stage_we),    64'(e.we));
        chk("stall_cnt",   64'(stall_cnt),   64'(e.sc));
        chk("flush_cnt",   64'(flush_cnt),   64'(e.fc));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset = 1'b0; id_valid = 1'b0; id_ctrl = '0; id_rd = '0; id_rd_we = 1'b0;
    id_is_load = 1'b0; id_rn = '0; id_rm = '0; id_use_rn = 1'b0; id_use_rm = 1'b0;
    branch_taken = 1'b0; ext_stall = 1'b0;
    for (int k = 0; k < int'(S); k++) m_pipe[k] = '{valid: 1'b0, ctrl: '0, rd: '0, we: 1'b0, ld: 1'b0};
    m_stall = 0;
    m_flush = 0;

    // Reset state
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hEE, 4'd1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use stall, then the dependent ADD re-presented and accepted
    ldr(8'hA1, 4'd2);
    alu(8'hB2, 4'd4, 4'd2, 4'd1, 1'b1, 1'b0);
    alu(8'hB2, 4'd4, 4'd2, 4'd1, 1'b1, 1'b0);

    // Non-load dependency: no stall
    alu(8'hC3, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
    alu(8'hC4, 4'd6, 4'd0, 4'd5, 1'b0, 1'b1);

    // Branch flush with a coincident load-use hazard
    ldr(8'hD1, 4'd3);
    cycle(1'b1, 1'b1, 8'hD2, 4'd7, 1'b1, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    nop();

    // ext_stall over a full pipeline, then drain
    alu(8'h11, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    alu(8'h22, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    ldr(8'h33, 4'd9);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 8'h44, 4'd8, 1'b1, 1'b0, 4'd9, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    nop(); nop(); nop();

    // Reset mid-stream, then one instruction walks the pipe
    alu(8'h55, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    alu(8'h66, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    alu(8'h77, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h88, 4'd4, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    alu(8'h99, 4'd15, 4'd0, 4'd0, 1'b0, 1'b0);
    nop(); nop();

    // Stall counter saturation (20 stalls, 4-bit counter); R15 gets no special case
    for (int i = 0; i < 20; i++) begin
      ldr(8'($urandom), (i % 2 == 0) ? 4'd15 : 4'd7);
      alu(8'hAB, 4'd1, (i % 2 == 0) ? 4'd15 : 4'd7, 4'd0, 1'b1, 1'b0);
      alu(8'hAC, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    end

    // Randomised traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
            ($urandom_range(0, 7) != 0),
            8'($urandom),
            4'($urandom_range(0, 3)),
            1'($urandom),
            1'($urandom),
            4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)),
            1'($urandom),
            1'($urandom),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0));
    end

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge clk);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
